// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator scheduler: floor range, FSM states
// and the SCAN direction decision used by the controller.
package elevator_pkg;

  localparam int NUM_FLOORS = 11;
  localparam int FLOOR_W    = 4;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN
  } state_e;

  typedef struct packed {
    state_e state;
    logic   dir_up;
  } decision_t;

  // SCAN: keep the current direction while requests lie ahead, reverse only when none do
  function automatic decision_t decide(input logic dir_up,
                                       input logic any_above,
                                       input logic any_below);
    decision_t d;
    d.state  = IDLE;
    d.dir_up = dir_up;
    if (dir_up) begin
      if (any_above) begin
        d.state = MOVE_UP;
      end else if (any_below) begin
        d.state  = MOVE_DOWN;
        d.dir_up = 1'b0;
      end
    end else begin
      if (any_below) begin
        d.state = MOVE_DOWN;
      end else if (any_above) begin
        d.state  = MOVE_UP;
        d.dir_up = 1'b1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/elevator_req_lookahead.sv
// Combinational summary of latched requests relative to a given floor:
// any request above, any below, and one exactly at that floor.
module elevator_req_lookahead
  import elevator_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    floor_bin,
  output logic                  any_above,
  output logic                  any_below,
  output logic                  here
);

  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    here      = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i]) begin
        if (FLOOR_W'(i) > floor_bin) any_above = 1'b1;
        if (FLOOR_W'(i) < floor_bin) any_below = 1'b1;
        if (FLOOR_W'(i) == floor_bin) here = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN elevator controller: latches calls, moves the car one floor per
// TRAVEL_CYCLES, opens the door for DOOR_CYCLES and clears served requests.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [FLOOR_W-1:0]    floor_bin,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  moving,
  output logic                  dir_up,
  output logic                  door_open,
  output logic                  arrive
);

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

  state_e                  state, state_next;
  logic [FLOOR_W-1:0]      floor_next, step_floor;
  logic [NUM_FLOORS-1:0]   pending_next, clr_mask, latch_mask;
  logic [NUM_FLOORS-1:0]   cur_onehot, step_onehot;
  logic                    dir_next, arrive_next, call_here;
  logic [TW-1:0]           travel_cnt, travel_next;
  logic [DW-1:0]           door_cnt, door_next;
  logic                    any_above_cur, any_below_cur, here_cur;
  logic                    any_above_step, any_below_step, here_step;
  decision_t               dec_cur, dec_step;

  // The second lookahead looks at the floor the car is about to reach, so the
  // arrival edge can decide stop / continue / reverse without an idle gap.
  elevator_req_lookahead u_look_cur (
    .pending   (pending),
    .floor_bin (floor_bin),
    .any_above (any_above_cur),
    .any_below (any_below_cur),
    .here      (here_cur)
  );

  elevator_req_lookahead u_look_step (
    .pending   (pending),
    .floor_bin (step_floor),
    .any_above (any_above_step),
    .any_below (any_below_step),
    .here      (here_step)
  );

  always_comb begin
    step_floor = floor_bin;
    if (state == MOVE_UP && floor_bin < FLOOR_W'(NUM_FLOORS - 1))
      step_floor = floor_bin + FLOOR_W'(1);
    else if (state == MOVE_DOWN && floor_bin != '0)
      step_floor = floor_bin - FLOOR_W'(1);
  end

  assign cur_onehot  = NUM_FLOORS'(1) << floor_bin;
  assign step_onehot = NUM_FLOORS'(1) << step_floor;
  assign call_here   = call_req[floor_bin];
  assign dec_cur     = decide(dir_up, any_above_cur, any_below_cur);
  assign dec_step    = decide(dir_up, any_above_step, any_below_step);

  // A call for the floor the car is standing at is answered by the door, not latched
  assign latch_mask   = (state == IDLE || state == DOOR_OPEN) ? cur_onehot : '0;
  assign pending_next = (pending | (call_req & ~latch_mask)) & ~clr_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      floor_bin  <= '0;
      pending    <= '0;
      dir_up     <= 1'b1;
      arrive     <= 1'b0;
      travel_cnt <= '0;
      door_cnt   <= '0;
    end else begin
      state      <= state_next;
      floor_bin  <= floor_next;
      pending    <= pending_next;
      dir_up     <= dir_next;
      arrive     <= arrive_next;
      travel_cnt <= travel_next;
      door_cnt   <= door_next;
    end
  end

  always_comb begin
    state_next  = state;
    dir_next    = dir_up;
    floor_next  = floor_bin;
    arrive_next = 1'b0;
    travel_next = '0;
    door_next   = '0;
    clr_mask    = '0;
    unique case (state)
      IDLE: begin
        if (here_cur || call_here) begin
          state_next = DOOR_OPEN;
          clr_mask   = cur_onehot;
        end else begin
          state_next = dec_cur.state;
          dir_next   = dec_cur.dir_up;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (travel_cnt == TRAVEL_LAST) begin
          floor_next  = step_floor;
          arrive_next = 1'b1;
          if (here_step) begin
            state_next = DOOR_OPEN;
            clr_mask   = step_onehot;
          end else begin
            state_next = dec_step.state;
            dir_next   = dec_step.dir_up;
          end
        end else begin
          travel_next = travel_cnt + TW'(1);
        end
      end
      DOOR_OPEN: begin
        if (call_here) begin
          door_next = '0;
        end else if (door_cnt == DOOR_LAST) begin
          state_next = dec_cur.state;
          dir_next   = dec_cur.dir_up;
        end else begin
          door_next = door_cnt + DW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    moving    = (state == MOVE_UP) || (state == MOVE_DOWN);
    door_open = (state == DOOR_OPEN);
  end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench for elevator_scheduler: expected arrival/door events are queued
// by the stimulus and checked by an independent monitor; cycle-exact checks inline.
module tb_elevator_scheduler;

  logic        clk;
  logic        reset;
  logic [10:0] call_req;
  logic [3:0]  floor_bin;
  logic [10:0] pending;
  logic        moving, dir_up, door_open, arrive;

  typedef struct packed {
    logic [3:0] floor;
    logic       door;
    logic       dir;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  logic prev_door = 1'b0;

  elevator_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .call_req  (call_req),
    .floor_bin (floor_bin),
    .pending   (pending),
    .moving    (moving),
    .dir_up    (dir_up),
    .door_open (door_open),
    .arrive    (arrive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  // Drive a one-edge call pulse starting at the current negedge
  task automatic applyStimulus(input logic [10:0] calls);
    call_req = calls;
    @(negedge clk);
    call_req = '0;
  endtask

  task automatic pushEvent(input int fl, input logic door, input logic dir);
    ev_t e;
    e.floor = 4'(fl);
    e.door  = door;
    e.dir   = dir;
    exp_q.push_back(e);
  endtask

  task automatic waitFloor(input logic [3:0] fl, input int budget);
    int n = 0;
    while (floor_bin !== fl && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_floor", 32'(floor_bin), 32'(fl));
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    while ((moving || door_open || arrive || pending != '0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {moving, door_open, arrive, (pending != '0)}, 4'b0000);
  endtask

  // Monitor: each arrival pulse or door opening is one event, matched in order
  initial begin : monitor
    ev_t got, want;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_door = 1'b0;
      end else begin
        if (arrive || (door_open && !prev_door)) begin
          got.floor = floor_bin;
          got.door  = door_open;
          got.dir   = dir_up;
          checkOutput("floor_in_range", 32'(floor_bin <= 4'd10), 32'd1);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_event: got floor=%0d door=%0b dir=%0b required no event",
                     got.floor, got.door, got.dir);
          end else begin
            want = exp_q.pop_front();
            checkOutput("event", 32'(got), 32'(want));
          end
        end
        prev_door = door_open;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic [18:0] exp_vec;
    int          ef;
    reset    = 1'b1;
    call_req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset and quiet hold");
    for (int k = 0; k < 20; k++) begin
      checkOutput("reset_hold", {floor_bin, pending, moving, door_open, arrive, dir_up},
                  {4'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1});
      @(negedge clk);
    end

    $display("[TB] single call to floor 3 with cycle timing");
    pushEvent(1, 1'b0, 1'b1);
    pushEvent(2, 1'b0, 1'b1);
    pushEvent(3, 1'b1, 1'b1);
    applyStimulus(11'h008);
    for (int k = 1; k <= 18; k++) begin
      ef = (k < 6) ? 0 : (k < 10) ? 1 : (k < 14) ? 2 : 3;
      exp_vec = {4'(ef), (k < 14) ? 11'h008 : 11'h000,
                 (k >= 2 && k <= 13), (k >= 14 && k <= 16),
                 (k == 6 || k == 10 || k == 14), 1'b1};
      checkOutput("floor3_timing", {floor_bin, pending, moving, door_open, arrive, dir_up}, 32'(exp_vec));
      if (k < 18) @(negedge clk);
    end

    $display("[TB] call at current floor while idle, then again during door");
    pushEvent(3, 1'b1, 1'b1);
    applyStimulus(11'h008);
    checkOutput("here_door_open", {door_open, pending}, {1'b1, 11'h000});
    @(negedge clk);
    applyStimulus(11'h008);
    checkOutput("here_no_latch", 32'(pending), 32'd0);
    for (int k = 3; k <= 6; k++) begin
      checkOutput("door_restart", 32'(door_open), 32'(k <= 5));
      @(negedge clk);
    end

    $display("[TB] SCAN from floor 3: serve 8, then reverse to 2");
    for (int f = 4; f <= 7; f++) pushEvent(f, 1'b0, 1'b1);
    pushEvent(8, 1'b1, 1'b1);
    for (int f = 7; f >= 3; f--) pushEvent(f, 1'b0, 1'b0);
    pushEvent(2, 1'b1, 1'b0);
    applyStimulus(11'h100);
    waitFloor(4'd5, 100);
    applyStimulus(11'h004);
    waitIdle("scan_done", 300);
    checkOutput("scan_final", {floor_bin, dir_up}, {4'd2, 1'b0});

    $display("[TB] top floor bound then descent to ground");
    for (int f = 3; f <= 5; f++) pushEvent(f, 1'b0, 1'b1);
    pushEvent(6, 1'b1, 1'b1);
    for (int f = 7; f <= 9; f++) pushEvent(f, 1'b0, 1'b1);
    pushEvent(10, 1'b1, 1'b1);
    applyStimulus(11'h040);
    waitFloor(4'd4, 100);
    applyStimulus(11'h400);
    waitIdle("top_done", 300);
    checkOutput("top_final", {floor_bin, dir_up}, {4'd10, 1'b1});
    for (int f = 9; f >= 1; f--) pushEvent(f, 1'b0, 1'b0);
    pushEvent(0, 1'b1, 1'b0);
    applyStimulus(11'h001);
    waitIdle("ground_done", 300);
    checkOutput("ground_final", {floor_bin, dir_up}, {4'd0, 1'b0});

    $display("[TB] reset while travelling between floors 2 and 3");
    pushEvent(1, 1'b0, 1'b1);
    pushEvent(2, 1'b0, 1'b1);
    applyStimulus(11'h220);
    waitFloor(4'd2, 100);
    @(negedge clk);
    checkOutput("pre_reset_busy", {moving, pending}, {1'b1, 11'h220});
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset", {floor_bin, pending, moving, door_open, arrive, dir_up},
                {4'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("post_reset_idle", {floor_bin, pending, moving, door_open}, {4'd0, 11'd0, 1'b0, 1'b0});

    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
Sequences the elevator car across floors 0..10 using a SCAN policy: latches hall/car call requests, selects direction, times travel between floors and door dwell, and clears served requests. Its floor_bin output is the 4-bit floor code that drives the existing 4-to-11 floor decoder for the floor indicator. Sits between the call-button inputs and the indicator/motor/door outputs.

Parameters:
NUM_FLOORS, 11, number of served floors; floor codes 0..NUM_FLOORS-1
FLOOR_W, 4, width of floor code
TRAVEL_CYCLES, 4, clock cycles to move one floor (>=1)
DOOR_CYCLES, 3, clock cycles door stays open (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
call_req  in  NUM_FLOORS  per-floor call; a 1 in any cycle registers a request for that floor
floor_bin  out  FLOOR_W  current car floor, binary; feeds the floor decoder
pending  out  NUM_FLOORS  latched, unserved requests
moving  out  1  high in MOVE_UP/MOVE_DOWN
dir_up  out  1  current/preferred direction, 1 = up
door_open  out  1  high in DOOR_OPEN
arrive  out  1  one-cycle pulse on the cycle floor_bin changes

Behaviour:
- Single clock domain, one clk; reset synchronous active-high. Reset mid-operation takes effect on the next edge regardless of state.
- Reset values: state IDLE, floor_bin 0, pending 0, moving 0, dir_up 1, door_open 0, arrive 0, timers 0.
- Request latch: pending[i] <= pending[i] | call_req[i], except bits cleared by service on the same edge. A call for the current floor while in IDLE or DOOR_OPEN is never latched: in DOOR_OPEN it restarts the door timer; in IDLE it causes IDLE->DOOR_OPEN.
- Lookahead (combinational, from pending and floor_bin): any_above, any_below, here.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- Decision rule D (used from IDLE, after door closes, and on arrival without stop): if dir_up: any_above -> MOVE_UP, else any_below -> MOVE_DOWN (dir_up<=0), else IDLE. If !dir_up: any_below -> MOVE_DOWN, else any_above -> MOVE_UP (dir_up<=1), else IDLE.
- IDLE: here (pending or call_req at current floor) -> DOOR_OPEN; else apply D. A request latched at edge t is acted upon at edge t+1.
- MOVE_x: travel counter loads 0 on entry, increments each cycle; on the edge where counter == TRAVEL_CYCLES-1: floor_bin +/-1, arrive=1 next cycle, counter reset. If pending at the new floor -> DOOR_OPEN and clear that bit on the same edge; else apply D at the new floor (may continue without gap).
- Floor bounds: MOVE_UP never entered at floor NUM_FLOORS-1, MOVE_DOWN never at 0 (guaranteed by D); floor_bin never exceeds NUM_FLOORS-1, no wrap.
- DOOR_OPEN: door counter loads 0 on entry; exits on the edge where counter == DOOR_CYCLES-1, applying D. A call for the current floor restarts the counter to 0.
- Simultaneous calls for several floors: all latched the same edge; service order strictly by SCAN.
- Requests arriving while moving for floors already passed wait until reversal.

Decomposition:
- Shared package elevator_pkg: state enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN), NUM_FLOORS, FLOOR_W constants.
- One sub-module: elevator_req_lookahead (pending, floor_bin -> any_above, any_below, here); purely combinational, separately testable.

Test Plan:
- Reset, no calls -> floor_bin=0, IDLE, door_open=0, dir_up=1 held for 20 cycles.
- From floor 0, call_req[3] pulse at cycle t -> moving from t+2; floor_bin 1,2,3 at t+6,t+10,t+14 with arrive pulses; door_open t+14..t+16; pending[3] cleared at t+14; IDLE at t+17.
- At floor 5 going up with pending {2,8} -> serves 8 first, then reverses (dir_up=0) and serves 2.
- call_req[0] at floor 0 in IDLE -> door_open next cycle, pending stays 0; repeat the call during DOOR_OPEN -> door counter restarts, door open total 3+n cycles.
- call_req[10] while moving up past 4 -> served at 10, floor_bin never >10; then call_req[0] -> descends to 0, no underflow.
- Assert reset while in MOVE_UP between floors 2 and 3 with pending set -> next edge all outputs at reset values, pending 0.
